// File: rtl/trigger_sequencer_if.sv
// Sample, configuration, command and status bundle for the trigger sequencer.
interface trigger_sequencer_if #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned COUNT_WIDTH  = 16
);
  localparam int unsigned STAGE_W = $clog2(NUM_STAGES);

  logic [SAMPLE_WIDTH-1:0] sampleData;
  logic                    sample_valid;
  logic                    cfg_we;
  logic [STAGE_W-1:0]      cfg_stage;
  logic [SAMPLE_WIDTH-1:0] cfg_mask;
  logic [SAMPLE_WIDTH-1:0] cfg_value;
  logic                    cfg_edge_en;
  logic                    cfg_edge_type;
  logic [7:0]              cfg_edge_chan;
  logic [COUNT_WIDTH-1:0]  cfg_count;
  logic [4:0]              cfg_num_stages;
  logic                    arm;
  logic                    abort;
  logic                    armed;
  logic [STAGE_W-1:0]      stage_idx;
  logic                    trigger;
  logic                    triggered;
  logic [31:0]             trigger_sample_num;

  modport master (
    output sampleData, sample_valid, cfg_we, cfg_stage, cfg_mask, cfg_value,
           cfg_edge_en, cfg_edge_type, cfg_edge_chan, cfg_count, cfg_num_stages,
           arm, abort,
    input  armed, stage_idx, trigger, triggered, trigger_sample_num
  );

  modport slave (
    input  sampleData, sample_valid, cfg_we, cfg_stage, cfg_mask, cfg_value,
           cfg_edge_en, cfg_edge_type, cfg_edge_chan, cfg_count, cfg_num_stages,
           arm, abort,
    output armed, stage_idx, trigger, triggered, trigger_sample_num
  );
endinterface

// File: rtl/trigger_sequencer.sv
// Multi-stage logic-analyser trigger: per-stage pattern/edge match with occurrence counts.
module trigger_sequencer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               reset,
  trigger_sequencer_if.slave bus
);
  localparam int unsigned STAGE_W = $clog2(NUM_STAGES);
  localparam int unsigned NSTG_W  = 5;
  localparam int unsigned SNUM_W  = 32;
  localparam int unsigned CHAN_W  = 8;

  typedef enum logic [1:0] {IDLE, ARMED, TRIGGERED} state_t;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] mask;
    logic [SAMPLE_WIDTH-1:0] value;
    logic                    edgeEn;
    logic                    edgeType;
    logic [CHAN_W-1:0]       edgeChan;
    logic [COUNT_WIDTH-1:0]  count;
  } stageCfg_t;

  stageCfg_t               cfgMem [NUM_STAGES];
  stageCfg_t               curCfg;

  state_t                  state, stateNext;
  logic [STAGE_W-1:0]      stageIdx, stageIdxNext;
  logic [COUNT_WIDTH-1:0]  matchCnt, matchCntNext;
  logic [SNUM_W-1:0]       sampleCnt, sampleCntNext;
  logic [SAMPLE_WIDTH-1:0] prevSample, prevSampleNext;
  logic                    prevValid, prevValidNext;
  logic [NSTG_W-1:0]       effStages, effStagesNext;
  logic [SNUM_W-1:0]       trigNum, trigNumNext;
  logic                    triggerQ, triggerNext;
  logic                    armedQ, triggeredQ;

  logic                    patternOk, edgeOk, chanOk, curBit, prevBit, stageMatch, lastStage;

  // Stage configuration store; writable only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) cfgMem[i] <= '0;
    end else if (state == IDLE && bus.cfg_we) begin
      cfgMem[bus.cfg_stage] <= '{mask:     bus.cfg_mask,
                                 value:    bus.cfg_value,
                                 edgeEn:   bus.cfg_edge_en,
                                 edgeType: bus.cfg_edge_type,
                                 edgeChan: bus.cfg_edge_chan,
                                 count:    bus.cfg_count};
    end
  end

  // Match condition of the current stage against the presented sample.
  always_comb begin
    curCfg     = cfgMem[stageIdx];
    patternOk  = (((bus.sampleData ^ curCfg.value) & curCfg.mask) == '0);
    curBit     = 1'(bus.sampleData >> curCfg.edgeChan);
    prevBit    = 1'(prevSample >> curCfg.edgeChan);
    chanOk     = (32'(curCfg.edgeChan) < SAMPLE_WIDTH);
    edgeOk     = !curCfg.edgeEn ||
                 (prevValid && chanOk &&
                  (curCfg.edgeType ? (!prevBit && curBit) : (prevBit && !curBit)));
    stageMatch = patternOk && edgeOk;
    lastStage  = (NSTG_W'(stageIdx) == (effStages - NSTG_W'(1)));
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext      = state;
    stageIdxNext   = stageIdx;
    matchCntNext   = matchCnt;
    sampleCntNext  = sampleCnt;
    prevSampleNext = prevSample;
    prevValidNext  = prevValid;
    effStagesNext  = effStages;
    trigNumNext    = trigNum;
    triggerNext    = 1'b0;
    if (bus.abort) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arm) begin
            stateNext     = ARMED;
            stageIdxNext  = '0;
            matchCntNext  = '0;
            sampleCntNext = '0;
            prevValidNext = 1'b0;
            trigNumNext   = '0;
            if (bus.cfg_num_stages == '0)
              effStagesNext = NSTG_W'(1);
            else if (bus.cfg_num_stages > NSTG_W'(NUM_STAGES))
              effStagesNext = NSTG_W'(NUM_STAGES);
            else
              effStagesNext = bus.cfg_num_stages;
          end
        end
        ARMED: begin
          if (bus.sample_valid) begin
            sampleCntNext  = (sampleCnt == '1) ? sampleCnt : sampleCnt + SNUM_W'(1);
            prevSampleNext = bus.sampleData;
            prevValidNext  = 1'b1;
            if (stageMatch) begin
              if (matchCnt == curCfg.count) begin
                matchCntNext = '0;
                if (lastStage) begin
                  stateNext   = TRIGGERED;
                  triggerNext = 1'b1;
                  trigNumNext = sampleCnt;
                end else begin
                  stageIdxNext = stageIdx + STAGE_W'(1);
                end
              end else begin
                matchCntNext = matchCnt + COUNT_WIDTH'(1);
              end
            end
          end
        end
        TRIGGERED: stateNext = TRIGGERED;
        default:   stateNext = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      stageIdx   <= '0;
      matchCnt   <= '0;
      sampleCnt  <= '0;
      prevSample <= '0;
      prevValid  <= 1'b0;
      effStages  <= NSTG_W'(1);
      trigNum    <= '0;
      triggerQ   <= 1'b0;
      armedQ     <= 1'b0;
      triggeredQ <= 1'b0;
    end else begin
      state      <= stateNext;
      stageIdx   <= stageIdxNext;
      matchCnt   <= matchCntNext;
      sampleCnt  <= sampleCntNext;
      prevSample <= prevSampleNext;
      prevValid  <= prevValidNext;
      effStages  <= effStagesNext;
      trigNum    <= trigNumNext;
      triggerQ   <= triggerNext;
      armedQ     <= (stateNext == ARMED);
      triggeredQ <= (stateNext == TRIGGERED);
    end
  end

  assign bus.armed              = armedQ;
  assign bus.stage_idx          = stageIdx;
  assign bus.trigger            = triggerQ;
  assign bus.triggered          = triggeredQ;
  assign bus.trigger_sample_num = trigNum;
endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer with hand-computed expectations.
module tb_trigger_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nErrors = 0;

  trigger_sequencer_if #(.SAMPLE_WIDTH(16), .NUM_STAGES(4), .COUNT_WIDTH(16)) bus ();

  trigger_sequencer #(.SAMPLE_WIDTH(16), .NUM_STAGES(4), .COUNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic writeStage(input int stg, input logic [15:0] m, input logic [15:0] v,
                            input logic en, input logic typ, input logic [7:0] ch,
                            input logic [15:0] cnt);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_stage = 2'(stg); bus.cfg_mask = m; bus.cfg_value = v;
    bus.cfg_edge_en = en; bus.cfg_edge_type = typ; bus.cfg_edge_chan = ch; bus.cfg_count = cnt;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic doArm(input logic [4:0] nStages);
    @(negedge clk);
    bus.arm = 1'b1; bus.cfg_num_stages = nStages;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic doAbort();
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  task automatic sendSample(input logic [15:0] d);
    @(negedge clk);
    bus.sampleData = d; bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  initial begin
    bus.sampleData = '0; bus.sample_valid = 1'b0; bus.cfg_we = 1'b0; bus.cfg_stage = '0;
    bus.cfg_mask = '0; bus.cfg_value = '0; bus.cfg_edge_en = 1'b0; bus.cfg_edge_type = 1'b0;
    bus.cfg_edge_chan = '0; bus.cfg_count = '0; bus.cfg_num_stages = 5'd1;
    bus.arm = 1'b0; bus.abort = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    checkValue("rst_armed", 32'(bus.armed), 0);
    checkValue("rst_stage", 32'(bus.stage_idx), 0);
    checkValue("rst_trigger", 32'(bus.trigger), 0);
    checkValue("rst_triggered", 32'(bus.triggered), 0);
    checkValue("rst_tsn", bus.trigger_sample_num, 0);
    reset = 1'b0;

    // Single-stage pattern match on the second sample
    writeStage(0, 16'h00FF, 16'h0042, 1'b0, 1'b0, 8'd0, 16'd0);
    doArm(5'd1);
    checkValue("p_armed", 32'(bus.armed), 1);
    checkValue("p_stage", 32'(bus.stage_idx), 0);
    sendSample(16'h1100);
    checkValue("p_nomatch_trig", 32'(bus.trigger), 0);
    sendSample(16'h0042);
    checkValue("p_trigger", 32'(bus.trigger), 1);
    checkValue("p_triggered", 32'(bus.triggered), 1);
    checkValue("p_armed_off", 32'(bus.armed), 0);
    checkValue("p_tsn", bus.trigger_sample_num, 1);
    @(negedge clk);
    checkValue("p_pulse_end", 32'(bus.trigger), 0);
    checkValue("p_level_hold", 32'(bus.triggered), 1);
    doArm(5'd1);
    checkValue("p_rearm_ignored", 32'(bus.triggered), 1);
    checkValue("p_rearm_armed", 32'(bus.armed), 0);
    doAbort();
    checkValue("p_abort_level", 32'(bus.triggered), 0);
    checkValue("p_abort_tsn_hold", bus.trigger_sample_num, 1);

    // Cumulative count: matches at indices 1, 3, 5
    writeStage(0, 16'hFFFF, 16'h00AA, 1'b0, 1'b0, 8'd0, 16'd2);
    doArm(5'd1);
    sendSample(16'h0000); sendSample(16'h00AA); sendSample(16'h0000); sendSample(16'h00AA);
    checkValue("c_two_matches", 32'(bus.trigger), 0);
    sendSample(16'h0000);
    sendSample(16'h00AA);
    checkValue("c_trigger", 32'(bus.trigger), 1);
    checkValue("c_tsn", bus.trigger_sample_num, 5);
    checkValue("c_stage", 32'(bus.stage_idx), 0);
    doAbort();

    // Two stages: pattern then rising edge on channel 3
    writeStage(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 8'd0, 16'd0);
    writeStage(1, 16'h0000, 16'h0000, 1'b1, 1'b1, 8'd3, 16'd0);
    doArm(5'd2);
    sendSample(16'h0001);
    checkValue("e_stage_adv", 32'(bus.stage_idx), 1);
    checkValue("e_no_trig0", 32'(bus.trigger), 0);
    sendSample(16'h0000);
    checkValue("e_no_edge", 32'(bus.trigger), 0);
    sendSample(16'h0008);
    checkValue("e_trigger", 32'(bus.trigger), 1);
    checkValue("e_tsn", bus.trigger_sample_num, 2);
    doAbort();

    // Edge-only stage: first sample already high must not match
    writeStage(0, 16'h0000, 16'h0000, 1'b1, 1'b1, 8'd0, 16'd0);
    doArm(5'd1);
    sendSample(16'h0001);
    checkValue("f_first_no_edge", 32'(bus.trigger), 0);
    checkValue("f_still_armed", 32'(bus.armed), 1);
    sendSample(16'h0001);
    sendSample(16'h0000);
    checkValue("f_fall_no_rise", 32'(bus.trigger), 0);
    sendSample(16'h0001);
    checkValue("f_trigger", 32'(bus.trigger), 1);
    checkValue("f_tsn", bus.trigger_sample_num, 3);
    doAbort();

    // Falling edge on channel 15
    writeStage(0, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'd15, 16'd0);
    doArm(5'd1);
    sendSample(16'h8000); sendSample(16'h8000);
    checkValue("g_no_fall", 32'(bus.trigger), 0);
    sendSample(16'h0000);
    checkValue("g_fall_trig", 32'(bus.trigger), 1);
    checkValue("g_tsn", bus.trigger_sample_num, 2);
    doAbort();

    // Out-of-range edge channel never matches
    writeStage(0, 16'h0000, 16'h0000, 1'b1, 1'b1, 8'd20, 16'd0);
    doArm(5'd1);
    sendSample(16'h0000); sendSample(16'hFFFF); sendSample(16'h0000); sendSample(16'hFFFF);
    checkValue("h_chan_oob_trig", 32'(bus.triggered), 0);
    checkValue("h_chan_oob_armed", 32'(bus.armed), 1);
    doAbort();

    // Stage-count clamping: 0 -> 1 stage, 31 -> 4 stages, all match-everything
    for (int s = 0; s < 4; s++) writeStage(s, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'd0, 16'd0);
    doArm(5'd0);
    sendSample(16'h1234);
    checkValue("k_clamp_lo_trig", 32'(bus.trigger), 1);
    checkValue("k_clamp_lo_tsn", bus.trigger_sample_num, 0);
    doAbort();
    doArm(5'd31);
    sendSample(16'h0001); sendSample(16'h0002); sendSample(16'h0003);
    checkValue("k_clamp_hi_wait", 32'(bus.triggered), 0);
    checkValue("k_clamp_hi_stage", 32'(bus.stage_idx), 3);
    sendSample(16'h0004);
    checkValue("k_clamp_hi_trig", 32'(bus.trigger), 1);
    checkValue("k_clamp_hi_tsn", bus.trigger_sample_num, 3);
    doAbort();

    // Abort wins over a simultaneous match
    doArm(5'd1);
    @(negedge clk);
    bus.sampleData = 16'h0055; bus.sample_valid = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0; bus.abort = 1'b0;
    checkValue("m_abort_trig", 32'(bus.trigger), 0);
    checkValue("m_abort_level", 32'(bus.triggered), 0);
    checkValue("m_abort_armed", 32'(bus.armed), 0);

    // Arm and abort together stays idle
    @(negedge clk);
    bus.arm = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0; bus.abort = 1'b0;
    checkValue("n_arm_abort_armed", 32'(bus.armed), 0);
    checkValue("n_arm_abort_trig", 32'(bus.triggered), 0);

    // Config write while armed is ignored; reset mid-armed abandons the sequence
    writeStage(0, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 8'd0, 16'd0);
    doArm(5'd1);
    writeStage(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'd0, 16'd0);
    sendSample(16'h0000);
    checkValue("r_cfg_ignored", 32'(bus.trigger), 0);
    checkValue("r_still_armed", 32'(bus.armed), 1);
    @(negedge clk);
    bus.sampleData = 16'h1234; bus.sample_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    checkValue("r_rst_armed", 32'(bus.armed), 0);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    checkValue("r_rst_trig", 32'(bus.trigger), 0);
    checkValue("r_rst_level", 32'(bus.triggered), 0);
    checkValue("r_rst_stage", 32'(bus.stage_idx), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkValue("r_post_trig", 32'(bus.triggered), 0);
    checkValue("r_post_armed", 32'(bus.armed), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
